pipe_stage_reg: RTL

//   Parametrised pipeline-boundary register (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_if.sv | 27 ++
 rtl/pipe_stage_reg.sv | 60 ++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between an upstream driver and a pipe_stage_reg chain.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             enable;
    logic             flush;
    logic             bubble;
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic [DEPTH-1:0] stage_valid;
    logic [CW-1:0]    valid_count;

    modport master (
        output enable, flush, bubble, valid_in, data_in,
        input  data_out, valid_out, stage_valid, valid_count
    );

    modport slave (
        input  enable, flush, bubble, valid_in, data_in,
        output data_out, valid_out, stage_valid, valid_count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage pipeline boundary register with stall, flush and bubble insertion.
// Any stage whose valid bit is clear always holds RESET_VAL.
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           reset,
    pipe_stage_reg_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 8 || WIDTH < 1) begin : g_param_check
        $error("pipe_stage_reg: DEPTH must be 1..8 and WIDTH >= 1");
    end

    logic [WIDTH-1:0] pay_p [DEPTH];
    logic [DEPTH-1:0] vld_p;
    logic             load_vld;

    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int k = 0; k < DEPTH; k++) begin
            n = n + CW'(v[k]);
        end
        return n;
    endfunction

    // A bubble wins over a live word; an empty slot is scrubbed to RESET_VAL.
    assign load_vld = bus.valid_in && !bus.bubble;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                pay_p[k] <= RESET_VAL;
            end
            vld_p <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                pay_p[k] <= RESET_VAL;
            end
            vld_p <= '0;
        end else if (bus.enable) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                pay_p[k] <= pay_p[k-1];
                vld_p[k] <= vld_p[k-1];
            end
            pay_p[0] <= load_vld ? bus.data_in : RESET_VAL;
            vld_p[0] <= load_vld;
        end
    end

    // Outputs come straight from the last stage registers.
    assign bus.data_out    = pay_p[DEPTH-1];
    assign bus.valid_out   = vld_p[DEPTH-1];
    assign bus.stage_valid = vld_p;
    assign bus.valid_count = popcount(vld_p);
endmodule
